// File: rtl/munoc_axi_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : munoc_axi_write_arbiter_if
// Brief    : AW + W channel bundle between NUM_REQ write requesters and the
//            single shared AXI slave write port.
// Revision : 1.0 - initial release
// ============================================================================
interface munoc_axi_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int BW_AW   = 64,
    parameter int BW_W    = 72
);
    // requester side
    logic [NUM_REQ-1:0]       s_awvalid;
    logic [NUM_REQ-1:0]       s_awready;
    logic [NUM_REQ*BW_AW-1:0] s_awpayload;
    logic [NUM_REQ-1:0]       s_wvalid;
    logic [NUM_REQ-1:0]       s_wready;
    logic [NUM_REQ-1:0]       s_wlast;
    logic [NUM_REQ*BW_W-1:0]  s_wpayload;

    // shared slave side
    logic                     m_awvalid;
    logic                     m_awready;
    logic [BW_AW-1:0]         m_awpayload;
    logic                     m_wvalid;
    logic                     m_wready;
    logic                     m_wlast;
    logic [BW_W-1:0]          m_wpayload;

    // arbiter view: accepts requester traffic, drives the shared port
    modport slave (
        input  s_awvalid, s_awpayload, s_wvalid, s_wlast, s_wpayload,
        input  m_awready, m_wready,
        output s_awready, s_wready,
        output m_awvalid, m_awpayload, m_wvalid, m_wlast, m_wpayload
    );

    // environment view: requesters plus the downstream slave
    modport master (
        output s_awvalid, s_awpayload, s_wvalid, s_wlast, s_wpayload,
        output m_awready, m_wready,
        input  s_awready, s_wready,
        input  m_awvalid, m_awpayload, m_wvalid, m_wlast, m_wpayload
    );
endinterface
`default_nettype wire

// File: rtl/munoc_axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : munoc_axi_write_arbiter
// Brief    : Round-robin AW arbiter with a registered grant; an order FIFO of
//            accepted AW indices steers the W channel so write data reaches
//            the slave in AW-acceptance order.
// Revision : 1.0 - initial release
// ============================================================================
module munoc_axi_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BW_AW      = 64,
    parameter int BW_W       = 72,
    parameter int FIFO_DEPTH = 4,
    parameter int BW_IDX     = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rstnn,
    munoc_axi_write_arbiter_if.slave   bus,
    output logic                       busy
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [BW_IDX-1:0]  c_LAST_IDX = BW_IDX'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BW_IDX-1:0]   r_gnt_idx;
    logic [BW_IDX-1:0]   r_rr_ptr;
    logic [BW_IDX-1:0]   w_cand;
    logic [BW_IDX-1:0]   w_pick_idx;
    logic                w_pick_vld;

    logic [BW_IDX-1:0]   r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [BW_IDX-1:0]   w_head;

    logic                w_aw_hs;
    logic                w_pop;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == c_DEPTH);
    assign w_head       = r_fifo_mem[r_rd_ptr];
    assign w_aw_hs      = bus.m_awvalid & bus.m_awready;
    assign w_pop        = bus.m_wvalid & bus.m_wready & bus.m_wlast;
    assign busy         = (r_state == ST_GRANT) | ~w_fifo_empty;

    // Round-robin search: walk offsets from the far end so the closest
    // request at or after rr_ptr is the one left standing.
    always_comb begin
        w_cand     = '0;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            w_cand = BW_IDX'((int'(r_rr_ptr) + j) % NUM_REQ);
            if (bus.s_awvalid[w_cand]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_cand;
            end
        end
    end

    // AW state register
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // AW next state and AW outputs, all derived from registered grant state
    always_comb begin
        w_state_nxt     = r_state;
        bus.m_awvalid   = 1'b0;
        bus.m_awpayload = '0;
        bus.s_awready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld && !w_fifo_full) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                bus.m_awvalid = 1'b1;
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (BW_IDX'(r) == r_gnt_idx) begin
                        bus.m_awpayload = bus.s_awpayload[r*BW_AW +: BW_AW];
                        bus.s_awready[r] = bus.m_awready;
                    end
                end
                if (bus.m_awready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant index is frozen on entry to GRANT; rr_ptr advances past the winner
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            r_gnt_idx <= '0;
            r_rr_ptr  <= '0;
        end else begin
            if (r_state == ST_IDLE && w_state_nxt == ST_GRANT) begin
                r_gnt_idx <= w_pick_idx;
            end
            if (w_aw_hs) begin
                r_rr_ptr <= (r_gnt_idx == c_LAST_IDX) ? '0 : r_gnt_idx + 1'b1;
            end
        end
    end

    // Order FIFO pointers and occupancy; push on AW handshake, pop on last W beat
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_aw_hs) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_aw_hs, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Order FIFO storage; contents are meaningless while count is zero
    always_ff @(posedge clk) begin
        if (w_aw_hs) begin
            r_fifo_mem[r_wr_ptr] <= r_gnt_idx;
        end
    end

    // W steering from the FIFO head; nothing passes while the FIFO is empty
    always_comb begin
        bus.m_wvalid   = 1'b0;
        bus.m_wlast    = 1'b0;
        bus.m_wpayload = '0;
        bus.s_wready   = '0;
        if (!w_fifo_empty) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (BW_IDX'(r) == w_head) begin
                    bus.m_wvalid    = bus.s_wvalid[r];
                    bus.m_wlast     = bus.s_wlast[r];
                    bus.m_wpayload  = bus.s_wpayload[r*BW_W +: BW_W];
                    bus.s_wready[r] = bus.m_wready;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_munoc_axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_munoc_axi_write_arbiter
// Brief    : Directed self-checking bench for munoc_axi_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_munoc_axi_write_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int BW_AW      = 64;
    localparam int BW_W       = 72;
    localparam int FIFO_DEPTH = 4;
    localparam int BW_IDX     = 2;

    logic clk = 1'b0;
    logic rstnn;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    munoc_axi_write_arbiter_if #(.NUM_REQ(NUM_REQ), .BW_AW(BW_AW), .BW_W(BW_W)) bus ();

    munoc_axi_write_arbiter #(
        .NUM_REQ(NUM_REQ), .BW_AW(BW_AW), .BW_W(BW_W),
        .FIFO_DEPTH(FIFO_DEPTH), .BW_IDX(BW_IDX)
    ) u_dut (
        .clk(clk), .rstnn(rstnn), .bus(bus), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [BW_AW-1:0] aw_pay(input int r);
        return 64'hA000_0000_0000_0000 + 64'(r) * 64'h1111;
    endfunction

    function automatic logic [BW_W-1:0] w_pay(input int r, input int b);
        return 72'hB0_0000_0000_0000_0000 + 72'(r * 16 + b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.s_awvalid = '0;
        bus.s_wvalid  = '0;
        bus.s_wlast   = '0;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            bus.s_awpayload[r*BW_AW +: BW_AW] = aw_pay(r);
            bus.s_wpayload[r*BW_W +: BW_W]    = w_pay(r, 0);
        end
    endtask

    task automatic do_reset();
        rstnn = 1'b0;
        clear_inputs();
        tick();
        tick();
        rstnn = 1'b1;
    endtask

    task automatic test_reset();
        rstnn = 1'b0;
        clear_inputs();
        bus.s_awvalid = 4'hF;
        bus.s_wvalid  = 4'hF;
        bus.s_wlast   = 4'hF;
        bus.m_wready  = 1'b1;
        tick(); tick(); tick();
        total++; if (bus.m_awvalid !== 1'b0) begin bad++; $display("FAIL reset_m_awvalid: got %b expected 0", bus.m_awvalid); end
        total++; if (bus.m_awpayload !== '0) begin bad++; $display("FAIL reset_m_awpayload: got %h expected 0", bus.m_awpayload); end
        total++; if (bus.m_wvalid !== 1'b0 || bus.m_wlast !== 1'b0) begin bad++; $display("FAIL reset_m_w: got wvalid=%b wlast=%b expected 0 0", bus.m_wvalid, bus.m_wlast); end
        total++; if (bus.m_wpayload !== '0) begin bad++; $display("FAIL reset_m_wpayload: got %h expected 0", bus.m_wpayload); end
        total++; if (bus.s_awready !== 4'h0 || bus.s_wready !== 4'h0) begin bad++; $display("FAIL reset_s_ready: got aw=%b w=%b expected 0000 0000", bus.s_awready, bus.s_wready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rstnn = 1'b1;
        #1;
        total++; if (bus.m_awvalid !== 1'b0) begin bad++; $display("FAIL release_same_cycle: got m_awvalid=%b expected 0", bus.m_awvalid); end
        tick();
        total++; if (bus.m_awvalid !== 1'b1 || bus.m_awpayload !== aw_pay(0)) begin bad++; $display("FAIL release_grant0: got valid=%b pay=%h expected 1 %h", bus.m_awvalid, bus.m_awpayload, aw_pay(0)); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL release_busy: got %b expected 1", busy); end
        bus.m_awready = 1'b1;
        #1;
        total++; if (bus.s_awready !== 4'b0001) begin bad++; $display("FAIL release_awready: got %b expected 0001", bus.s_awready); end
    endtask

    task automatic test_round_robin();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        logic [NUM_REQ-1:0] onehot;
        do_reset();
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        bus.s_wvalid  = 4'hF;
        bus.s_wlast   = 4'hF;
        bus.s_awvalid = 4'hF;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i % 2 == 0) begin
                onehot = 4'b0001 << exp_g[i/2];
                total++; if (bus.m_awvalid !== 1'b1 || bus.s_awready !== onehot || bus.m_awpayload !== aw_pay(exp_g[i/2])) begin
                    bad++; $display("FAIL rr_grant i=%0d: got valid=%b awready=%b pay=%h expected 1 %b %h", i, bus.m_awvalid, bus.s_awready, bus.m_awpayload, onehot, aw_pay(exp_g[i/2]));
                end
                total++; if (bus.m_wvalid !== 1'b0) begin bad++; $display("FAIL rr_w_idle i=%0d: got m_wvalid=%b expected 0", i, bus.m_wvalid); end
            end else begin
                onehot = 4'b0001 << exp_g[(i-1)/2];
                total++; if (bus.m_awvalid !== 1'b0) begin bad++; $display("FAIL rr_gap i=%0d: got m_awvalid=%b expected 0", i, bus.m_awvalid); end
                total++; if (bus.s_wready !== onehot || bus.m_wpayload !== w_pay(exp_g[(i-1)/2], 0)) begin
                    bad++; $display("FAIL rr_w_steer i=%0d: got wready=%b pay=%h expected %b %h", i, bus.s_wready, bus.m_wpayload, onehot, w_pay(exp_g[(i-1)/2], 0));
                end
            end
        end
        bus.s_awvalid = '0;
    endtask

    task automatic test_ordering();
        do_reset();
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        bus.s_awvalid = 4'b0100;
        tick();
        total++; if (bus.s_awready !== 4'b0100) begin bad++; $display("FAIL ord_aw2: got awready=%b expected 0100", bus.s_awready); end
        bus.s_awvalid = 4'b0001;
        bus.s_wvalid  = 4'b0001;
        bus.s_wlast   = 4'b0001;
        tick();
        total++; if (bus.s_wready !== 4'b0100 || bus.m_wvalid !== 1'b0) begin bad++; $display("FAIL ord_early_w0: got wready=%b m_wvalid=%b expected 0100 0", bus.s_wready, bus.m_wvalid); end
        tick();
        total++; if (bus.s_awready !== 4'b0001) begin bad++; $display("FAIL ord_aw0: got awready=%b expected 0001", bus.s_awready); end
        bus.s_awvalid = '0;
        bus.s_wvalid  = 4'b0101;
        for (int b = 0; b < 4; b++) begin
            bus.s_wpayload[2*BW_W +: BW_W] = w_pay(2, b);
            bus.s_wlast[2] = (b == 3);
            #1;
            total++; if (bus.s_wready !== 4'b0100 || bus.m_wvalid !== 1'b1 || bus.m_wpayload !== w_pay(2, b) || bus.m_wlast !== (b == 3)) begin
                bad++; $display("FAIL ord_beat2 b=%0d: got wready=%b valid=%b pay=%h last=%b expected 0100 1 %h %b", b, bus.s_wready, bus.m_wvalid, bus.m_wpayload, bus.m_wlast, w_pay(2, b), (b == 3));
            end
            tick();
        end
        bus.s_wvalid = 4'b0001;
        #1;
        total++; if (bus.s_wready !== 4'b0001 || bus.m_wvalid !== 1'b1 || bus.m_wpayload !== w_pay(0, 0) || bus.m_wlast !== 1'b1) begin
            bad++; $display("FAIL ord_beat0: got wready=%b valid=%b pay=%h last=%b expected 0001 1 %h 1", bus.s_wready, bus.m_wvalid, bus.m_wpayload, bus.m_wlast, w_pay(0, 0));
        end
        tick();
        total++; if (bus.m_wvalid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ord_drained: got m_wvalid=%b busy=%b expected 0 0", bus.m_wvalid, busy); end
        bus.s_wvalid = '0;
    endtask

    task automatic test_full();
        do_reset();
        bus.m_awready = 1'b1;
        bus.s_awvalid = 4'hF;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i % 2 == 1) begin
                total++; if (bus.s_awready !== (4'b0001 << ((i-1)/2))) begin bad++; $display("FAIL full_fill i=%0d: got awready=%b expected %b", i, bus.s_awready, 4'b0001 << ((i-1)/2)); end
            end
        end
        for (int i = 8; i <= 11; i++) begin
            tick();
            total++; if (bus.m_awvalid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL full_hold i=%0d: got m_awvalid=%b busy=%b expected 0 1", i, bus.m_awvalid, busy); end
        end
        bus.s_wvalid[0] = 1'b1;
        bus.s_wlast[0]  = 1'b1;
        bus.m_wready    = 1'b1;
        #1;
        total++; if (bus.s_wready !== 4'b0001 || bus.m_wvalid !== 1'b1) begin bad++; $display("FAIL full_pop: got wready=%b m_wvalid=%b expected 0001 1", bus.s_wready, bus.m_wvalid); end
        tick();
        bus.s_wvalid[0] = 1'b0;
        #1;
        total++; if (bus.m_awvalid !== 1'b0 || bus.s_wready !== 4'b0010) begin bad++; $display("FAIL full_after_pop: got m_awvalid=%b wready=%b expected 0 0010", bus.m_awvalid, bus.s_wready); end
        tick();
        total++; if (bus.m_awvalid !== 1'b1 || bus.s_awready !== 4'b0001) begin bad++; $display("FAIL full_fifth: got m_awvalid=%b awready=%b expected 1 0001", bus.m_awvalid, bus.s_awready); end
        bus.s_awvalid = '0;
    endtask

    task automatic test_push_pop();
        do_reset();
        bus.m_awready = 1'b1;
        bus.s_awvalid = 4'b1010;
        tick();
        total++; if (bus.s_awready !== 4'b0010) begin bad++; $display("FAIL pp_aw1: got awready=%b expected 0010", bus.s_awready); end
        tick();
        tick();
        total++; if (bus.s_awready !== 4'b1000) begin bad++; $display("FAIL pp_aw3: got awready=%b expected 1000", bus.s_awready); end
        bus.s_awvalid = 4'b0001;
        tick();
        total++; if (bus.m_awvalid !== 1'b0 || bus.m_wvalid !== 1'b0) begin bad++; $display("FAIL pp_idle: got m_awvalid=%b m_wvalid=%b expected 0 0", bus.m_awvalid, bus.m_wvalid); end
        tick();
        bus.s_wvalid[1] = 1'b1;
        bus.s_wlast[1]  = 1'b1;
        bus.m_wready    = 1'b1;
        #1;
        total++; if (bus.s_awready !== 4'b0001 || bus.s_wready !== 4'b0010 || bus.m_wlast !== 1'b1) begin
            bad++; $display("FAIL pp_both: got awready=%b wready=%b wlast=%b expected 0001 0010 1", bus.s_awready, bus.s_wready, bus.m_wlast);
        end
        bus.s_awvalid = '0;
        tick();
        bus.s_wvalid = 4'b1000;
        bus.s_wlast  = 4'b1000;
        #1;
        total++; if (bus.s_wready !== 4'b1000 || bus.m_wpayload !== w_pay(3, 0)) begin bad++; $display("FAIL pp_head3: got wready=%b pay=%h expected 1000 %h", bus.s_wready, bus.m_wpayload, w_pay(3, 0)); end
        tick();
        bus.s_wvalid = 4'b0001;
        bus.s_wlast  = 4'b0001;
        #1;
        total++; if (bus.s_wready !== 4'b0001 || bus.m_wvalid !== 1'b1) begin bad++; $display("FAIL pp_head0: got wready=%b m_wvalid=%b expected 0001 1", bus.s_wready, bus.m_wvalid); end
        tick();
        bus.s_wvalid = 4'hF;
        #1;
        total++; if (bus.m_wvalid !== 1'b0 || bus.s_wready !== 4'h0 || busy !== 1'b0) begin bad++; $display("FAIL pp_empty: got m_wvalid=%b wready=%b busy=%b expected 0 0000 0", bus.m_wvalid, bus.s_wready, busy); end
        bus.s_wvalid = '0;
        bus.s_wlast  = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.m_awready = 1'b1;
        bus.s_awvalid = 4'b0010;
        tick();
        total++; if (bus.s_awready !== 4'b0010) begin bad++; $display("FAIL mid_aw1: got awready=%b expected 0010", bus.s_awready); end
        bus.s_awvalid = '0;
        tick();
        bus.s_wvalid[1] = 1'b1;
        bus.m_wready    = 1'b1;
        #1;
        total++; if (bus.m_wvalid !== 1'b1 || bus.s_wready !== 4'b0010) begin bad++; $display("FAIL mid_beat1: got m_wvalid=%b wready=%b expected 1 0010", bus.m_wvalid, bus.s_wready); end
        tick();
        bus.s_wpayload[1*BW_W +: BW_W] = w_pay(1, 1);
        rstnn = 1'b0;
        #1;
        total++; if (bus.m_wvalid !== 1'b1 || bus.m_wpayload !== w_pay(1, 1)) begin bad++; $display("FAIL mid_beat2: got m_wvalid=%b pay=%h expected 1 %h", bus.m_wvalid, bus.m_wpayload, w_pay(1, 1)); end
        tick();
        total++; if (bus.m_wvalid !== 1'b0 || bus.s_wready !== 4'h0 || busy !== 1'b0) begin bad++; $display("FAIL mid_flushed: got m_wvalid=%b wready=%b busy=%b expected 0 0000 0", bus.m_wvalid, bus.s_wready, busy); end
        rstnn = 1'b1;
        bus.s_awvalid = 4'hF;
        tick();
        total++; if (bus.m_awvalid !== 1'b1 || bus.s_awready !== 4'b0001) begin bad++; $display("FAIL mid_rr_cleared: got m_awvalid=%b awready=%b expected 1 0001", bus.m_awvalid, bus.s_awready); end
        bus.s_awvalid = '0;
        bus.s_wvalid  = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_ordering();
        test_full();
        test_push_pop();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/munoc_axi_write_arbiter.md
# munoc_axi_write_arbiter

Shares one AXI slave write port (AW + W channels) among NUM_REQ write requesters, for example several slave-side network interfaces or a network interface plus a local master in front of one memory controller. It picks AW requests round-robin with a registered grant. An order FIFO records each accepted AW, and that order steers the W channel, so write data always reaches the slave in AW-acceptance order, as AXI requires.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- BW_AW, 64, packed AW payload width per requester (id, addr, len, size, burst)
- BW_W, 72, packed W payload width per requester (data + strb)
- FIFO_DEPTH, 4, AW→W order FIFO entries (power of two, ≥2)
- BW_IDX, 2, clog2(NUM_REQ); must match NUM_REQ
- clk  input  1  block clock
- rstnn  input  1  synchronous active-low reset
- s_awvalid  input  NUM_REQ  per-requester AW valid
- s_awready  output  NUM_REQ  per-requester AW ready
- s_awpayload  input  NUM_REQ*BW_AW  requester r occupies [r*BW_AW +: BW_AW]
- s_wvalid  input  NUM_REQ  per-requester W valid
- s_wready  output  NUM_REQ  per-requester W ready
- s_wlast  input  NUM_REQ  per-requester W last
- s_wpayload  input  NUM_REQ*BW_W  requester r occupies [r*BW_W +: BW_W]
- m_awvalid / m_awready  output / input  1  shared AW handshake
- m_awpayload  output  BW_AW  muxed AW payload
- m_wvalid / m_wready  output / input  1  shared W handshake
- m_wlast  output  1  muxed W last
- m_wpayload  output  BW_W  muxed W payload
- busy  output  1  grant held or order FIFO non-empty

## Operation
- Clock and reset: already decided. One clock, `clk`; reset `rstnn` is synchronous and active-low.
- AW state machine, two states:
  - IDLE: if any s_awvalid is high and fifo_count < FIFO_DEPTH, register gnt_idx as the first set request at or after rr_ptr (circular), then go to GRANT. Otherwise stay in IDLE.
  - GRANT: m_awvalid = 1. m_awpayload = s_awpayload[gnt_idx]. s_awready[gnt_idx] = m_awready; every other s_awready = 0.
  - On the m_awvalid & m_awready handshake: push gnt_idx into the order FIFO, set rr_ptr = gnt_idx + 1 (wrapping at NUM_REQ), return to IDLE.
- Payload stability: gnt_idx does not change while in GRANT. Requesters must hold s_awvalid and payload until accepted (AXI rule); the block does not check this.
- W channel, combinational steering from the FIFO head:
  - If the FIFO is non-empty with head h: m_wvalid = s_wvalid[h], m_wlast = s_wlast[h], m_wpayload = s_wpayload[h], s_wready[h] = m_wready.
  - All other s_wready = 0. If the FIFO is empty: m_wvalid = 0 and every s_wready = 0.
- FIFO pop: on m_wvalid & m_wready & m_wlast. Beats without last never pop.
- Simultaneous push and pop: allowed; fifo_count stays unchanged.
- Full FIFO: IDLE does not grant while fifo_count == FIFO_DEPTH. A push is therefore never attempted when full.
- Empty FIFO: a pop is impossible, since m_wvalid is 0.
- W before AW: a requester driving s_wvalid before its AW is accepted sees s_wready = 0 until its index reaches the FIFO head.
- Width rules:
  - rr_ptr and gnt_idx are BW_IDX bits and wrap modulo NUM_REQ (not modulo 2^BW_IDX).
  - fifo_count is clog2(FIFO_DEPTH)+1 bits.
  - FIFO pointers wrap at FIFO_DEPTH.
- Reset: returns to IDLE, rr_ptr = 0, gnt_idx = 0, FIFO empty (count 0, pointers 0). A transfer in progress is abandoned with no drain.

## Timing
- Reset values: m_awvalid = 0, m_awpayload = 0, m_wvalid = 0, m_wlast = 0, m_wpayload = 0, s_awready = 0, s_wready = 0, busy = 0.
- AW latency:
  - s_awvalid rises in cycle n (IDLE, FIFO not full) → m_awvalid high in cycle n+1.
  - Handshake in cycle k → earliest next grant registered at the end of k+1, with m_awvalid high in k+2. Peak rate is one AW per 2 cycles.
- W latency: AW handshake in cycle k (FIFO previously empty) → steering to that requester begins in cycle k+1.
- W throughput: one beat per cycle while s_wvalid and m_wready are both high.
- Next burst: after a pop on the last beat in cycle k, the next head is steered in k+1 with no bubble beyond that.
- Zero-cycle paths: m_wready → s_wready and s_wvalid → m_wvalid are combinational. All AW outputs are driven from registered state.

## Test plan
- Reset: hold rstnn = 0 for 3 cycles while all s_awvalid are high → all outputs 0, busy = 0. Release reset → m_awvalid rises exactly 1 cycle later with gnt_idx = 0.
- Round-robin under full load (NUM_REQ = 4, m_awready = 1): all four s_awvalid held high → grant order 0,1,2,3,0. One AW every 2 cycles.
- Ordering: AW from requester 2 (len 3, 4 beats), then requester 0 (len 0); requester 0 raises s_wvalid first → s_wready[0] stays 0 until all 4 beats of requester 2 complete with wlast. Requester 0's beat then passes the next cycle.
- Full FIFO (FIFO_DEPTH = 4): 4 AWs accepted, W held off → no 5th m_awvalid. The single-beat W for the head completes → the 5th AW is granted 1 cycle after the pop, and m_awvalid rises the cycle after that.
- Simultaneous push and pop: AW handshake in the same cycle as a wlast pop at count 2 → count stays 2 and FIFO contents are in correct order.
- Reset mid-burst: rstnn driven low during beat 2 of 4 → next cycle FIFO empty, m_wvalid = 0, s_wready all 0, rr_ptr = 0.
